// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the program-memory address and loads the instruction register.
// Fetch control handles start-up, halt/resume, stall, branch redirect and skip.
module fetch_unit #(
    parameter int unsigned p = 5,
    parameter int unsigned i = 20
) (
    input  logic         clk,
    input  logic         reset,
    output logic [p-1:0] addr,
    input  logic [i-1:0] instr_code,
    input  logic         stall,
    input  logic         halt,
    input  logic         resume,
    input  logic         branch_en,
    input  logic [p-1:0] branch_addr,
    input  logic         skip,
    output logic [i-1:0] ir,
    output logic         ir_valid,
    output logic [p-1:0] pc,
    output logic         pc_wrap,
    output logic [15:0]  fetch_count
);

    typedef enum logic [1:0] {
        StStart,
        StRun,
        StHalt
    } state_e;

    state_e       state_q, state_d;
    logic [p-1:0] fptr_q, fptr_d;
    logic [p-1:0] pc_q, pc_d;
    logic [i-1:0] ir_q, ir_d;
    logic         ir_valid_q, ir_valid_d;
    logic         pc_wrap_q, pc_wrap_d;
    logic [15:0]  fetch_count_q, fetch_count_d;

    logic         fptr_at_max;
    logic         count_sat;

    assign fptr_at_max = &fptr_q;
    assign count_sat   = &fetch_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StStart;
            fptr_q        <= '0;
            pc_q          <= '0;
            ir_q          <= '0;
            ir_valid_q    <= 1'b0;
            pc_wrap_q     <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fptr_q        <= fptr_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_valid_q    <= ir_valid_d;
            pc_wrap_q     <= pc_wrap_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fptr_d        = fptr_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_valid_d    = ir_valid_q;
        pc_wrap_d     = 1'b0;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            StStart: begin
                state_d = StRun;
            end

            StRun: begin
                // Priority: halt > stall > branch > skip > normal fetch.
                if (halt) begin
                    state_d    = StHalt;
                    ir_valid_d = 1'b0;
                end else if (stall) begin
                    // Hold everything; a pending branch is re-presented once stall drops.
                end else if (branch_en) begin
                    fptr_d     = branch_addr;
                    ir_d       = '0;
                    ir_valid_d = 1'b0;
                end else begin
                    ir_d       = instr_code;
                    pc_d       = fptr_q;
                    fptr_d     = fptr_q + 1'b1;
                    pc_wrap_d  = fptr_at_max;
                    ir_valid_d = ~skip;
                    if (!skip && !count_sat) begin
                        fetch_count_d = fetch_count_q + 16'd1;
                    end
                end
            end

            StHalt: begin
                // resume only counts when halt is no longer requested; no fetch on the exit cycle.
                if (!halt && resume) begin
                    state_d = StRun;
                end
            end

            default: begin
                state_d = StStart;
            end
        endcase
    end

    assign addr        = fptr_q;
    assign ir          = ir_q;
    assign ir_valid    = ir_valid_q;
    assign pc          = pc_q;
    assign pc_wrap     = pc_wrap_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random control traffic,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int unsigned P     = 5;
    localparam int unsigned I     = 20;
    localparam int unsigned Depth = 1 << P;

    localparam int ModeStart = 0;
    localparam int ModeRun   = 1;
    localparam int ModeHalt  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [P-1:0] addr;
    logic [I-1:0] instr_code;
    logic         stall, halt, resume, branch_en, skip;
    logic [P-1:0] branch_addr;
    logic [I-1:0] ir;
    logic         ir_valid;
    logic [P-1:0] pc;
    logic         pc_wrap;
    logic [15:0]  fetch_count;

    logic [I-1:0] mem [Depth];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int           m_mode;
    int           m_fptr;
    int           m_pc;
    logic [I-1:0] m_ir;
    bit           m_valid;
    bit           m_wrap;
    int           m_cnt;

    always #5 clk = ~clk;

    assign instr_code = mem[addr];

    fetch_unit #(
        .p(P),
        .i(I)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .instr_code (instr_code),
        .stall      (stall),
        .halt       (halt),
        .resume     (resume),
        .branch_en  (branch_en),
        .branch_addr(branch_addr),
        .skip       (skip),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .pc_wrap    (pc_wrap),
        .fetch_count(fetch_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock of the fetch rules, applied with the inputs present at the edge.
    task automatic model_edge(input bit r, input bit h, input bit rs, input bit st,
                              input bit br, input bit sk, input int ba);
        m_wrap = 1'b0;
        if (r) begin
            m_mode  = ModeStart;
            m_fptr  = 0;
            m_pc    = 0;
            m_ir    = '0;
            m_valid = 1'b0;
            m_cnt   = 0;
            return;
        end
        if (m_mode == ModeStart) begin
            m_mode = ModeRun;
        end else if (m_mode == ModeHalt) begin
            if (!h && rs) m_mode = ModeRun;
        end else if (h) begin
            m_mode  = ModeHalt;
            m_valid = 1'b0;
        end else if (st) begin
            // nothing moves
        end else if (br) begin
            m_fptr  = ba;
            m_ir    = '0;
            m_valid = 1'b0;
        end else begin
            m_ir    = mem[m_fptr];
            m_pc    = m_fptr;
            m_valid = !sk;
            if (!sk && m_cnt < 65535) m_cnt++;
            m_wrap  = (m_fptr == Depth - 1);
            m_fptr  = (m_fptr + 1) % Depth;
        end
    endtask

    task automatic step(input bit r, input bit h, input bit rs, input bit st,
                        input bit br, input bit sk, input int ba);
        reset       = r;
        halt        = h;
        resume      = rs;
        stall       = st;
        branch_en   = br;
        skip        = sk;
        branch_addr = P'(ba);
        @(posedge clk);
        model_edge(r, h, rs, st, br, sk, ba);
        #1;
        check_eq("addr", 32'(addr), 32'(m_fptr));
        check_eq("ir", 32'(ir), 32'(m_ir));
        check_eq("ir_valid", 32'(ir_valid), 32'(m_valid));
        check_eq("pc", 32'(pc), 32'(m_pc));
        check_eq("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
        check_eq("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 2 * Depth && int'(addr) != target; k++) idle();
        check_eq("run_to", 32'(addr), 32'(target));
    endtask

    initial begin
        int wraps;
        for (int k = 0; k < Depth; k++) mem[k] = I'($urandom);
        m_mode = ModeStart; m_fptr = 0; m_pc = 0; m_ir = '0; m_valid = 0; m_wrap = 0; m_cnt = 0;
        {reset, halt, resume, stall, branch_en, skip} = '0;
        branch_addr = '0;

        // Reset, then free run
        do_reset();
        check_eq("rst_ir", 32'(ir), 32'd0);
        check_eq("rst_cnt", 32'(fetch_count), 32'd0);
        idle();                                      // START
        check_eq("start_addr", 32'(addr), 32'd0);
        idle();
        check_eq("first_ir", 32'(ir), 32'(mem[0]));
        check_eq("first_cnt", 32'(fetch_count), 32'd1);
        idle();
        check_eq("second_ir", 32'(ir), 32'(mem[1]));
        check_eq("second_pc", 32'(pc), 32'd1);
        idle();

        // Wrap from the top address
        run_to(Depth - 1);
        wraps = 0;
        idle();
        check_eq("wrap_addr", 32'(addr), 32'd0);
        check_eq("wrap_pc", 32'(pc), 32'(Depth - 1));
        check_eq("wrap_ir", 32'(ir), 32'(mem[Depth-1]));
        wraps += int'(pc_wrap);
        idle();
        wraps += int'(pc_wrap);
        check_eq("wrap_once", 32'(wraps), 32'd1);

        // Branch to 20 from fptr 3
        run_to(3);
        step(0, 0, 0, 0, 1, 0, 20);
        check_eq("br_bubble_ir", 32'(ir), 32'd0);
        check_eq("br_addr", 32'(addr), 32'd20);
        idle();
        check_eq("br_target_ir", 32'(ir), 32'(mem[20]));
        check_eq("br_target_pc", 32'(pc), 32'd20);

        // Branch to 0 must not pulse pc_wrap
        step(0, 0, 0, 0, 1, 0, 0);
        check_eq("br0_nowrap", 32'(pc_wrap), 32'd0);

        // Stall with pending branch, then halt/resume
        run_to(7);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 1, 0, 12);
        check_eq("stall_addr", 32'(addr), 32'd7);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1, 25);
        check_eq("halt_valid", 32'(ir_valid), 32'd0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle();
        check_eq("resume_pc", 32'(pc), 32'd7);

        // Skip with branch, then skip alone at 9
        step(0, 0, 0, 0, 1, 1, 9);
        check_eq("skipbr_valid", 32'(ir_valid), 32'd0);
        step(0, 0, 0, 0, 0, 1, 0);
        check_eq("skip_pc", 32'(pc), 32'd9);
        check_eq("skip_ir", 32'(ir), 32'(mem[9]));

        // Reset mid-HALT and mid-branch
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check_eq("rst_halt_valid", 32'(ir_valid), 32'd0);
        idle(); idle();
        step(0, 0, 0, 0, 1, 0, 17);
        step(1, 0, 0, 0, 1, 0, 17);
        check_eq("rst_br_addr", 32'(addr), 32'd0);
        idle(); idle();
        check_eq("rst_br_ir", 32'(ir), 32'(mem[0]));

        // Random control traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 12,
                 int'($urandom_range(0, Depth - 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter p, default 5, program-memory address width, matching prog_mem p.
REQ-002 Parameter i, default 20, instruction width, matching prog_mem i.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising Clock edge.
REQ-005 addr  output  p  program-memory address, driven to prog_mem addr.
REQ-006 instr_code  input  i  instruction word returned combinationally by prog_mem for addr.
REQ-007 stall  input  1  hold all fetch state this cycle.
REQ-008 halt  input  1  enter HALT state.
REQ-009 resume  input  1  leave HALT state.
REQ-010 branch_en  input  1  redirect fetch to branch_addr.
REQ-011 branch_addr  input  p  branch target.
REQ-012 skip  input  1  invalidate the word fetched this cycle.
REQ-013 ir  output  i  instruction register.
REQ-014 ir_valid  output  1  ir holds an executable instruction.
REQ-015 pc  output  p  address of the word currently in ir.
REQ-016 pc_wrap  output  1  one-cycle pulse when the fetch address wraps from 2^p-1 to 0.
REQ-017 fetch_count  output  16  count of valid instructions loaded into ir, saturating.

Function
REQ-018 addr shall equal the internal fetch pointer fptr combinationally, with no added latency.
REQ-019 States: START, RUN, HALT.
- START shall last exactly one cycle after Reset deasserts, then move to RUN.
- In START, ir and ir_valid shall not change.
REQ-020 Each RUN cycle, when no higher-priority event is present, the block shall perform a normal fetch:
- ir<=instr_code, pc<=fptr, ir_valid<=1, fptr<=fptr+1 modulo 2^p.
- The instruction at addr is therefore visible on ir one cycle after addr presents it.
REQ-021 Event priority shall be Reset > halt > stall > branch_en > skip > normal fetch.
REQ-022 halt in RUN: next state HALT, ir_valid<=0, fptr/ir/pc held; in HALT, stall, branch_en and skip shall be ignored.
REQ-023 resume in HALT (with halt low) shall move to RUN with no fetch that cycle; halt high shall keep HALT regardless of resume.
REQ-024 stall in RUN: fptr, ir, pc, ir_valid, fetch_count held; no pc_wrap pulse.
REQ-025 branch_en in RUN:
- fptr<=branch_addr, ir<=0, ir_valid<=0 (one bubble).
- Fetch from branch_addr occurs the following cycle.
REQ-026 skip in RUN: as a normal fetch, except ir_valid<=0 and fetch_count not incremented.
REQ-027 pc_wrap shall be 1 for exactly the cycle after a normal or skip fetch advances fptr from 2^p-1 to 0; a branch to 0 shall not assert it.
REQ-028 fetch_count shall increment by 1 on each cycle ir_valid is loaded with 1 and saturate at 16'hFFFF.
REQ-029 Simultaneous branch_en and skip: the branch wins; skip is dropped.
REQ-030 branch_en together with stall shall be ignored entirely; the requester holds branch_en until stall drops.

Reset
REQ-031 Reset high at a rising edge shall force the following, overriding every other input including mid-branch and HALT:
- fptr=0, pc=0, ir=0, ir_valid=0, pc_wrap=0, fetch_count=0, state=START.
REQ-032 While Reset is held high, addr shall read 0 and no output shall change.

Verification
REQ-033 Reset then 4 free-running cycles, mem[0..2]=A,B,C -> addr 0,0(START),1,2; ir A,B on successive cycles with ir_valid=1; pc 0,1; fetch_count 1,2.
REQ-034 Run to fptr=31, no events -> addr 31 then 0, pc_wrap=1 for one cycle, pc=31 with ir=mem[31].
REQ-035 branch_en=1, branch_addr=5'd20 at fptr=3 -> next cycle ir=0, ir_valid=0, addr=20; cycle after, ir=mem[20], pc=20, ir_valid=1; pc_wrap stays 0.
REQ-036 stall for 3 cycles at fptr=7 -> addr stays 7, ir/pc/fetch_count unchanged; halt for 2 cycles then resume -> ir_valid=0 during HALT, fetch restarts at the held address one cycle after resume.
REQ-037 skip and branch_en together -> branch taken, one bubble; skip alone at fptr=9 -> pc=9, ir=mem[9], ir_valid=0, fetch_count unchanged.
REQ-038 Reset asserted mid-HALT and mid-branch -> all outputs zero next cycle, START then RUN from address 0.
